// File: rtl/adder_pkg.sv
// adder_pkg: shared width helpers for pipelined arithmetic blocks.
package adder_pkg;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic int out_width(input int dw, input int n);
      return dw + clog2(n);
   endfunction
   function automatic bit legal_count(input int n);
      return n >= 2 && n <= 16 && (n & (n - 1)) == 0;
   endfunction
   // bit offset of stage s output inside the concatenated tree bus
   function automatic int stage_offset(input int dw, input int n, input int s);
      int o;
      o = 0;
      for (int t = 0; t < s; t++) o += (n >> (t + 1)) * (dw + t + 1);
      return o;
   endfunction
endpackage

// File: rtl/adder_stage.sv
// adder_stage: one registered level of the adder tree, summing adjacent operand pairs.
module adder_stage #(
   parameter int IN_WIDTH = 16,
   parameter int NUM_IN   = 4,
   parameter int SIGNED   = 0
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 en_i,
   input  logic                                 valid_i,
   input  logic [NUM_IN*IN_WIDTH-1:0]           data_i,
   output logic                                 valid_o,
   output logic [(NUM_IN/2)*(IN_WIDTH+1)-1:0]   data_o
);
   localparam int OW = IN_WIDTH + 1;
   localparam int NO = NUM_IN / 2;
   logic [NO*OW-1:0] sum;
   for (genvar j = 0; j < NO; j++) begin : g_pair
      logic [IN_WIDTH-1:0] a, b;
      assign a = data_i[2*j*IN_WIDTH +: IN_WIDTH];
      assign b = data_i[(2*j+1)*IN_WIDTH +: IN_WIDTH];
      assign sum[j*OW +: OW] = {SIGNED != 0 && a[IN_WIDTH-1], a} + {SIGNED != 0 && b[IN_WIDTH-1], b};
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         valid_o <= 1'b0;
         data_o  <= '0;
      end else if (en_i) begin
         valid_o <= valid_i;
         data_o  <= sum;
      end
endmodule

// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined binary adder tree with a single global stall enable.
module adder_tree_pipe
   import adder_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_INPUTS = 4,
   parameter int SIGNED     = 0,
   localparam int LEVELS    = clog2(NUM_INPUTS),
   localparam int OUT_WIDTH = out_width(DATA_WIDTH, NUM_INPUTS)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_i,
   input  logic                           valid_i,
   output logic                           ready_o,
   output logic [OUT_WIDTH-1:0]           data_o,
   output logic                           valid_o,
   input  logic                           ready_i
);
   localparam int TOTAL = stage_offset(DATA_WIDTH, NUM_INPUTS, LEVELS);
   logic [TOTAL-1:0]  tree;
   logic [LEVELS-1:0] vld;
   logic              en;
   if (!legal_count(NUM_INPUTS)) begin : g_bad
      $error("adder_tree_pipe: NUM_INPUTS must be a power of two in 2..16");
   end
   // every stage advances together; a full, unaccepted output freezes the tree
   assign en      = ~valid_o | ready_i;
   assign ready_o = en;
   for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
      localparam int IW  = DATA_WIDTH + s;
      localparam int NI  = NUM_INPUTS >> s;
      localparam int OFF = stage_offset(DATA_WIDTH, NUM_INPUTS, s);
      logic [NI*IW-1:0] din;
      logic             vin;
      if (s == 0) begin : g_head
         assign din = data_i;
         assign vin = valid_i;
      end else begin : g_body
         assign din = tree[stage_offset(DATA_WIDTH, NUM_INPUTS, s - 1) +: NI*IW];
         assign vin = vld[s-1];
      end
      adder_stage #(.IN_WIDTH(IW), .NUM_IN(NI), .SIGNED(SIGNED)) u_stage (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .en_i    (en),
         .valid_i (vin),
         .data_i  (din),
         .valid_o (vld[s]),
         .data_o  (tree[OFF +: (NI/2)*(IW+1)])
      );
   end
   assign valid_o = vld[LEVELS-1];
   assign data_o  = tree[TOTAL-OUT_WIDTH +: OUT_WIDTH];
endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb_adder_tree_pipe: directed checks of three adder tree configurations.
module tb_adder_tree_pipe;
   logic clk = 1'b0;
   logic rst;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;

   logic [63:0] a_data;
   logic        a_valid_i, a_ready_o, a_valid_o, a_ready_i;
   logic [17:0] a_sum;
   logic [31:0] b_data;
   logic        b_valid_i, b_ready_o, b_valid_o, b_ready_i;
   logic [9:0]  b_sum;
   logic [63:0] c_data;
   logic        c_valid_i, c_ready_o, c_valid_o, c_ready_i;
   logic [7:0]  c_sum;

   adder_tree_pipe #(.DATA_WIDTH(16), .NUM_INPUTS(4), .SIGNED(0)) u_a (
      .clk_i(clk), .rst_i(rst), .data_i(a_data), .valid_i(a_valid_i), .ready_o(a_ready_o),
      .data_o(a_sum), .valid_o(a_valid_o), .ready_i(a_ready_i));
   adder_tree_pipe #(.DATA_WIDTH(8), .NUM_INPUTS(4), .SIGNED(1)) u_b (
      .clk_i(clk), .rst_i(rst), .data_i(b_data), .valid_i(b_valid_i), .ready_o(b_ready_o),
      .data_o(b_sum), .valid_o(b_valid_o), .ready_i(b_ready_i));
   adder_tree_pipe #(.DATA_WIDTH(4), .NUM_INPUTS(16), .SIGNED(0)) u_c (
      .clk_i(clk), .rst_i(rst), .data_i(c_data), .valid_i(c_valid_i), .ready_o(c_ready_o),
      .data_o(c_sum), .valid_o(c_valid_o), .ready_i(c_ready_i));

   function automatic logic [63:0] set_data(input int k);
      logic [63:0] d;
      for (int j = 0; j < 4; j++)
         d[j*16 +: 16] = 16'(k * 4099 + j * 12345 + 77 * j * k) ^ ((j % 2 == 1) ? 16'hF000 : 16'h0000);
      return d;
   endfunction

   function automatic logic [17:0] set_sum(input int k);
      logic [63:0] d;
      int s;
      d = set_data(k);
      s = 0;
      for (int j = 0; j < 4; j++) s += int'(d[j*16 +: 16]);
      return 18'(s);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests++; if (a_valid_o !== 1'b0 || a_sum !== 18'h0) begin fails++; $display("FAIL reset_a valid=%b data=%h want 0/0", a_valid_o, a_sum); end
      tests++; if (b_valid_o !== 1'b0 || b_sum !== 10'h0) begin fails++; $display("FAIL reset_b valid=%b data=%h want 0/0", b_valid_o, b_sum); end
      tests++; if (c_valid_o !== 1'b0 || c_sum !== 8'h0) begin fails++; $display("FAIL reset_c valid=%b data=%h want 0/0", c_valid_o, c_sum); end
      rst = 1'b0;
      @(negedge clk);
      #1;
      tests++; if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1 || c_ready_o !== 1'b1) begin fails++; $display("FAIL ready_after_reset got %b%b%b want 111", a_ready_o, b_ready_o, c_ready_o); end
   endtask

   task automatic test_max_unsigned();
      int lat;
      @(negedge clk);
      a_data = {4{16'hFFFF}};
      a_valid_i = 1'b1;
      lat = 0;
      @(negedge clk);
      a_valid_i = 1'b0;
      lat = 1;
      while (!a_valid_o && lat < 10) begin @(negedge clk); lat++; end
      tests++; if (lat !== 2) begin fails++; $display("FAIL max_latency got %0d want 2", lat); end
      tests++; if (a_sum !== 18'h3FFFC) begin fails++; $display("FAIL max_sum got %h want 3fffc", a_sum); end
      @(negedge clk);
      tests++; if (a_valid_o !== 1'b0) begin fails++; $display("FAIL max_single_output valid=%b want 0", a_valid_o); end
   endtask

   task automatic test_signed();
      logic [31:0] vec [3] = '{32'h017F8080, 32'h80808080, 32'h7F7F7F7F};
      logic [9:0]  exp [3] = '{10'h380, 10'h200, 10'h1FC};
      int k = 0;
      int first = -1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (b_valid_o) begin
            if (first < 0) first = c;
            tests++; if (k > 2 || b_sum !== exp[k % 3]) begin fails++; $display("FAIL signed_sum[%0d] got %h want %h", k, b_sum, exp[k % 3]); end
            k++;
         end
         b_valid_i = c < 3;
         b_data = vec[c % 3];
      end
      tests++; if (first !== 2 || k !== 3) begin fails++; $display("FAIL signed_timing first=%0d count=%0d want 2/3", first, k); end
   endtask

   task automatic test_wide();
      logic [7:0] exp [2] = '{8'd120, 8'd240};
      int lat;
      for (int v = 0; v < 2; v++) begin
         @(negedge clk);
         for (int j = 0; j < 16; j++) c_data[j*4 +: 4] = (v == 0) ? 4'(j) : 4'hF;
         c_valid_i = 1'b1;
         @(negedge clk);
         c_valid_i = 1'b0;
         lat = 1;
         while (!c_valid_o && lat < 12) begin @(negedge clk); lat++; end
         tests++; if (lat !== 4) begin fails++; $display("FAIL wide_latency[%0d] got %0d want 4", v, lat); end
         tests++; if (c_sum !== exp[v]) begin fails++; $display("FAIL wide_sum[%0d] got %0d want %0d", v, c_sum, exp[v]); end
      end
   endtask

   task automatic test_stream();
      logic [17:0] q [$];
      logic [17:0] want;
      int got = 0;
      int first = -1;
      int last = -1;
      a_ready_i = 1'b1;
      for (int c = 0; c < 106; c++) begin
         @(negedge clk);
         if (a_valid_o) begin
            want = (q.size() > 0) ? q.pop_front() : 18'h0;
            tests++; if (a_sum !== want) begin fails++; $display("FAIL stream_sum[%0d] got %h want %h", got, a_sum, want); end
            got++;
            if (first < 0) first = c;
            last = c;
         end
         a_valid_i = c < 100;
         a_data = set_data(c);
         if (c < 100) q.push_back(set_sum(c));
      end
      a_valid_i = 1'b0;
      tests++; if (got !== 100 || last - first !== 99) begin fails++; $display("FAIL stream_count got %0d over %0d cycles want 100 over 99", got, last - first); end
   endtask

   task automatic test_back_to_back_stall();
      logic [31:0] pat = 32'hB53C9A61;
      logic [17:0] q [$];
      logic [17:0] held, want;
      logic stall = 1'b0;
      int sent = 0;
      int outs = 0;
      for (int c = 0; c < 300 && outs < 40; c++) begin
         @(negedge clk);
         if (stall) begin
            tests++; if (a_valid_o !== 1'b1 || a_sum !== held) begin fails++; $display("FAIL stall_hold c=%0d valid=%b data=%h want 1/%h", c, a_valid_o, a_sum, held); end
         end
         a_ready_i = (c >= 150) ? 1'b1 : pat[c % 32];
         a_valid_i = sent < 40;
         a_data = set_data(sent + 1000);
         #1;
         tests++; if (a_ready_o !== (!a_valid_o || a_ready_i)) begin fails++; $display("FAIL ready_tracks_en c=%0d got %b want %b", c, a_ready_o, !a_valid_o || a_ready_i); end
         if (a_valid_o && a_ready_i) begin
            want = (q.size() > 0) ? q.pop_front() : 18'h0;
            tests++; if (a_sum !== want) begin fails++; $display("FAIL stall_sum[%0d] got %h want %h", outs, a_sum, want); end
            outs++;
         end
         if (a_valid_i && a_ready_o) begin
            q.push_back(set_sum(sent + 1000));
            sent++;
         end
         stall = a_valid_o && !a_ready_i;
         held = a_sum;
      end
      a_valid_i = 1'b0;
      a_ready_i = 1'b1;
      tests++; if (outs !== 40 || q.size() !== 0) begin fails++; $display("FAIL stall_count got %0d left %0d want 40/0", outs, q.size()); end
   endtask

   task automatic test_reset_flight();
      int lat;
      a_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      a_data = set_data(7);
      a_valid_i = 1'b1;
      @(negedge clk);
      a_data = set_data(8);
      @(negedge clk);
      a_valid_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      tests++; if (a_valid_o !== 1'b0 || a_sum !== 18'h0) begin fails++; $display("FAIL flight_reset valid=%b data=%h want 0/0", a_valid_o, a_sum); end
      tests++; if (a_ready_o !== 1'b1) begin fails++; $display("FAIL flight_reset_ready got %b want 1", a_ready_o); end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         tests++; if (a_valid_o !== 1'b0) begin fails++; $display("FAIL flight_stale c=%0d valid=%b want 0", c, a_valid_o); end
      end
      a_data = set_data(9);
      a_valid_i = 1'b1;
      @(negedge clk);
      a_valid_i = 1'b0;
      lat = 1;
      while (!a_valid_o && lat < 10) begin @(negedge clk); lat++; end
      tests++; if (lat !== 2 || a_sum !== set_sum(9)) begin fails++; $display("FAIL flight_restart lat=%0d data=%h want 2/%h", lat, a_sum, set_sum(9)); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_data = '0; b_data = '0; c_data = '0;
      a_valid_i = 1'b0; b_valid_i = 1'b0; c_valid_i = 1'b0;
      a_ready_i = 1'b1; b_ready_i = 1'b1; c_ready_i = 1'b1;
      test_reset();
      test_max_unsigned();
      test_signed();
      test_wide();
      test_stream();
      test_back_to_back_stall();
      test_reset_flight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/adder_tree_pipe.md
ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each input operand.
REQ-002 Parameter NUM_INPUTS, default 4: operand count, power of two, 2..16.
REQ-003 Parameter SIGNED, default 0: 1 = two's-complement operands and sign extension; 0 = unsigned with zero extension.
REQ-004 Derived constant LEVELS = log2(NUM_INPUTS); OUT_WIDTH = DATA_WIDTH + LEVELS.
REQ-005 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 data_i  input  NUM_INPUTS*DATA_WIDTH  packed operands; operand k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 valid_i  input  1  data_i holds a new operand set.
REQ-009 ready_o  output  1  block accepts data_i this cycle.
REQ-010 data_o  output  OUT_WIDTH  full-precision sum of one accepted operand set.
REQ-011 valid_o  output  1  data_o holds a valid sum.
REQ-012 ready_i  input  1  downstream accepts data_o this cycle.

Function
REQ-013 The block SHALL form a binary tree of LEVELS registered stages; stage s holds NUM_INPUTS/2^(s+1) partial sums of width DATA_WIDTH+s+1.
REQ-014 Each stage SHALL add adjacent pairs (2j, 2j+1) of the previous level, each operand extended by one bit according to SIGNED.
REQ-015 data_o SHALL equal the exact sum of the NUM_INPUTS operands; no overflow, truncation or saturation for any input.
REQ-016 Latency SHALL be exactly LEVELS cycles from an accepting edge (valid_i & ready_o) to valid_o high, absent back-pressure.
REQ-017 A global advance enable SHALL be en = ~valid_o | ready_i; ready_o SHALL equal en (combinational).
REQ-018 When en = 1 every stage register and its valid bit SHALL load from the previous stage; stage 0 valid loads valid_i.
REQ-019 When en = 0 all stage data and valid bits SHALL hold; data_o and valid_o SHALL remain stable until ready_i.
REQ-020 Pipeline bubbles (valid bit 0) SHALL propagate without producing valid_o; data contents of invalid stages are don't-care.
REQ-021 Throughput SHALL be one sum per cycle while ready_i = 1 continuously.
REQ-022 valid_i asserted while ready_o = 0 SHALL NOT be accepted; the source must hold data_i until ready_o.
REQ-023 Sums SHALL exit in acceptance order; no set is dropped or duplicated under any ready_i pattern.

Reset
REQ-024 While rst_i = 1, all stage valid bits and valid_o SHALL be 0 and data_o SHALL be 0, asynchronously.
REQ-025 Assertion of rst_i mid-operation SHALL discard all in-flight sums; after release the first valid_o follows the next accepted set by LEVELS cycles.
REQ-026 ready_o SHALL be 1 in the first cycle after reset release.

Structure
REQ-027 A shared package adder_pkg SHALL hold the clog2 constant function and the OUT_WIDTH derivation, reused by later arithmetic blocks.
REQ-028 One sub-module adder_stage SHALL implement one registered tree level (parameters IN_WIDTH, NUM_IN, SIGNED; ports clk_i, rst_i, en_i, valid/data in and out), instantiated LEVELS times via generate.
REQ-029 Elaboration SHALL fail if NUM_INPUTS is not a power of two in 2..16.

Verification
REQ-030 Unsigned, DATA_WIDTH=16, NUM_INPUTS=4: operands all 0xFFFF, ready_i=1 -> after 2 cycles valid_o=1, data_o=18'h3FFFC.
REQ-031 SIGNED=1, DATA_WIDTH=8, NUM_INPUTS=4: operands 0x80,0x80,0x7F,0x01 -> data_o=10'h380 (-128).
REQ-032 Streaming 100 random sets with ready_i=1 -> 100 outputs, one per cycle, matching a reference model in order.
REQ-033 Random ready_i toggling (50%) with continuous valid_i -> outputs hold stable while ready_i=0, none lost or repeated, ready_o tracks en.
REQ-034 rst_i pulsed while 2 sets in flight -> valid_o=0 and data_o=0 immediately; no stale sum appears after release.
REQ-035 NUM_INPUTS=16, DATA_WIDTH=4, operands 0..15 -> after 4 cycles data_o=8'd120.
